// File: rtl/quad_input_conditioner_pkg.sv
// Shared types and constants for the quad input conditioner (SW/A/B front end).
// Optional per-channel glitch counters are enabled by QUAD_INPUT_GLITCH_CNT_EN.
package quad_input_pkg;

  typedef enum logic [1:0] {
    ST_LO      = 2'b00,
    ST_WAIT_HI = 2'b01,
    ST_HI      = 2'b11,
    ST_WAIT_LO = 2'b10
  } state_t;

  localparam int GLITCH_CNT_W        = 8;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  // Saturating increment for the glitch counters.
  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/quad_input_conditioner_debounce_channel.sv
// One input channel: synchronizer chain, 4-state debounce FSM, registered pulses.
// With QUAD_INPUT_GLITCH_CNT_EN a saturating abort counter is added.
module debounce_channel
  import quad_input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
`ifdef QUAD_INPUT_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   clean_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LO;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Terminal compare sits ahead of the increment, so cnt never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_LO: if (s) begin
        state_nxt = ST_WAIT_HI;
        cnt_nxt   = CW'(1);
      end
      ST_WAIT_HI: begin
        if (!s)               state_nxt = ST_LO;
        else if (cnt == TERM) state_nxt = ST_HI;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      ST_HI: if (!s) begin
        state_nxt = ST_WAIT_LO;
        cnt_nxt   = CW'(1);
      end
      ST_WAIT_LO: begin
        if (s)                state_nxt = ST_HI;
        else if (cnt == TERM) state_nxt = ST_LO;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = ST_LO;
    endcase
  end

  // Clean level is encoded in state bit 1 (HI and WAIT_LO both hold 1).
  always_comb begin
    clean_nxt = state_nxt[1];
    rise_nxt  = (state == ST_WAIT_HI) && (state_nxt == ST_HI);
    fall_nxt  = (state == ST_WAIT_LO) && (state_nxt == ST_LO);
  end

`ifdef QUAD_INPUT_GLITCH_CNT_EN
  logic                    glitch;
  logic [GLITCH_CNT_W-1:0] gcnt;

  assign glitch = ((state == ST_WAIT_HI) && !s) || ((state == ST_WAIT_LO) && s);

  always_ff @(posedge clk) begin
    if (rst)         gcnt <= '0;
    else if (glitch) gcnt <= sat_inc(gcnt);
  end
  assign glitch_cnt = gcnt;
`endif

endmodule

// File: rtl/quad_input_conditioner.sv
// Top: NUM_CH independent debounce channels (bit 0 SW, bit 1 A, bit 2 B).
// QUAD_INPUT_GLITCH_CNT_EN adds the packed per-channel glitch_cnt port.
module quad_input_conditioner
  import quad_input_pkg::*;
#(
  parameter int NUM_CH          = 3,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
`ifdef QUAD_INPUT_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W*NUM_CH-1:0] glitch_cnt
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw        (raw_in[i]),
      .clean      (clean_out[i]),
      .rise       (rise_pulse[i]),
      .fall       (fall_pulse[i])
`ifdef QUAD_INPUT_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt[GLITCH_CNT_W*i +: GLITCH_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_quad_input_conditioner.sv
// Directed bench for quad_input_conditioner at defaults (2 sync stages, 16-cycle debounce).
// Edge k = k-th active edge after an input change; clean/pulses expected at k = 18.
module tb_quad_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw_in = 3'b000;
  logic [2:0] clean_out, rise_pulse, fall_pulse;
`ifdef QUAD_INPUT_GLITCH_CNT_EN
  logic [23:0] glitch_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  quad_input_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
`ifdef QUAD_INPUT_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] ec, er;
    rst = 1'b1; raw_in = 3'b111;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== 9'b0) begin
        miscompares++;
        $display("FAIL reset_hold k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, 9'b0);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      ec = (k >= 18) ? 3'b111 : 3'b000;
      er = (k == 18) ? 3'b111 : 3'b000;
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== {ec, er, 3'b000}) begin
        miscompares++;
        $display("FAIL reset_release k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, {ec, er, 3'b000});
      end
    end
  endtask

  task automatic test_all_fall();
    logic [2:0] ec, ef;
    raw_in = 3'b000;
    for (int k = 1; k <= 19; k++) begin
      tick();
      ec = (k >= 18) ? 3'b000 : 3'b111;
      ef = (k == 18) ? 3'b111 : 3'b000;
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== {ec, 3'b000, ef}) begin
        miscompares++;
        $display("FAIL all_fall k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, {ec, 3'b000, ef});
      end
    end
  endtask

  task automatic test_clean_edge();
    logic [2:0] ec, er, ef;
    raw_in = 3'b010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      ec = (k >= 18) ? 3'b010 : 3'b000;
      er = (k == 18) ? 3'b010 : 3'b000;
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== {ec, er, 3'b000}) begin
        miscompares++;
        $display("FAIL clean_rise k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, {ec, er, 3'b000});
      end
    end
    raw_in = 3'b000;
    for (int k = 1; k <= 20; k++) begin
      tick();
      ec = (k >= 18) ? 3'b000 : 3'b010;
      ef = (k == 18) ? 3'b010 : 3'b000;
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== {ec, 3'b000, ef}) begin
        miscompares++;
        $display("FAIL clean_fall k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, {ec, 3'b000, ef});
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 30; k++) begin
      raw_in = (k <= 10) ? 3'b100 : 3'b000;
      tick();
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== 9'b0) begin
        miscompares++;
        $display("FAIL glitch k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, 9'b0);
      end
    end
`ifdef QUAD_INPUT_GLITCH_CNT_EN
    vectors++;
    if (glitch_cnt[23:16] !== 8'd1) begin
      miscompares++;
      $display("FAIL glitch_cnt_ch2: got %0d expected %0d", glitch_cnt[23:16], 1);
    end
`endif
  endtask

  task automatic test_boundary();
    logic [2:0] ec, er, ef;
    // 15 samples high: one short of qualifying
    for (int k = 1; k <= 35; k++) begin
      raw_in = (k <= 15) ? 3'b001 : 3'b000;
      tick();
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== 9'b0) begin
        miscompares++;
        $display("FAIL boundary15 k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, 9'b0);
      end
    end
    // 16 samples high: qualifies at edge 18, then falls at edge 34
    for (int k = 1; k <= 40; k++) begin
      raw_in = (k <= 16) ? 3'b001 : 3'b000;
      tick();
      ec = (k >= 18 && k < 34) ? 3'b001 : 3'b000;
      er = (k == 18) ? 3'b001 : 3'b000;
      ef = (k == 34) ? 3'b001 : 3'b000;
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== {ec, er, ef}) begin
        miscompares++;
        $display("FAIL boundary16 k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, {ec, er, ef});
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] ec, er;
    raw_in = 3'b001;
    // edge 14 leaves cnt=12; edge 15 is the reset edge
    for (int k = 1; k <= 15; k++) begin
      rst = (k == 15);
      tick();
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== 9'b0) begin
        miscompares++;
        $display("FAIL mid_reset_pre k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, 9'b0);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      ec = (k >= 18) ? 3'b001 : 3'b000;
      er = (k == 18) ? 3'b001 : 3'b000;
      vectors++;
      if ({clean_out, rise_pulse, fall_pulse} !== {ec, er, 3'b000}) begin
        miscompares++;
        $display("FAIL mid_reset_requal k=%0d: got %b expected %b", k, {clean_out, rise_pulse, fall_pulse}, {ec, er, 3'b000});
      end
    end
  endtask

`ifdef QUAD_INPUT_GLITCH_CNT_EN
  task automatic test_saturation();
    raw_in = 3'b000; rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (glitch_cnt !== 24'd0) begin
      miscompares++;
      $display("FAIL sat_reset: got %h expected %h", glitch_cnt, 24'd0);
    end
    for (int g = 0; g < 306; g++) begin
      raw_in = 3'b001; repeat (3) tick();
      raw_in = 3'b000; repeat (3) tick();
      if (g == 299 || g == 305) begin
        vectors++;
        if (glitch_cnt[7:0] !== 8'd255 || clean_out !== 3'b000) begin
          miscompares++;
          $display("FAIL sat_ch0 g=%0d: got cnt=%0d clean=%b expected cnt=255 clean=000", g, glitch_cnt[7:0], clean_out);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_fall();
    test_clean_edge();
    test_glitch();
    test_boundary();
    test_mid_reset();
`ifdef QUAD_INPUT_GLITCH_CNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quad_input_conditioner.md
Name: quad_input_conditioner

Overview:
- Front-end conditioner for the mechanical switch and quadrature inputs (SW, A, B) that drive the rotary/step counter controller.
- Per channel: a synchronizer, then a debounce FSM. Outputs are a clean level, a one-cycle rise pulse and a one-cycle fall pulse.
- The counter controller consumes clean levels only. Raw pins never reach its FSM.

Parameters:
- NUM_CH, 3, number of independent input channels (bit 0 = SW, bit 1 = A, bit 2 = B by convention).
- SYNC_STAGES, 2, flip-flops in each synchronizer chain; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive identical synchronized samples required to accept a new level; legal range 2..65535.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- raw_in  input  NUM_CH  asynchronous raw pin levels.
- clean_out  output  NUM_CH  debounced levels.
- rise_pulse  output  NUM_CH  one-cycle strobe when clean_out goes 0->1.
- fall_pulse  output  NUM_CH  one-cycle strobe when clean_out goes 1->0.
- glitch_cnt  output  8*NUM_CH  per-channel glitch count; present only with the optional feature.

Behaviour:
- Reset: synchronous, active-high. All synchronizer flops, counters, clean_out, rise_pulse, fall_pulse and glitch_cnt are cleared to 0, and every channel FSM enters ST_LO.
- Reset asserted mid-debounce discards any partial count. No pulse is emitted on the reset edge or on the edge that releases reset.
- Synchronizer: s[i] is raw_in[i] delayed by SYNC_STAGES flops. No logic between the flops.
- Per-channel FSM has 4 states.
  - ST_LO: clean=0. If s=1: go to ST_WAIT_HI, cnt<=1. Otherwise stay.
  - ST_WAIT_HI: clean=0.
    - If s=0: go to ST_LO (glitch event).
    - Else if cnt==DEBOUNCE_CYCLES-1: go to ST_HI, clean<=1, rise<=1.
    - Else cnt<=cnt+1.
  - ST_HI: clean=1. If s=0: go to ST_WAIT_LO, cnt<=1.
  - ST_WAIT_LO: mirror of ST_WAIT_HI.
    - If s=1: go to ST_HI (glitch event).
    - At terminal count: go to ST_LO, clean<=0, fall<=1.
- Latency: raw_in is first captured at edge 1. clean_out then changes on edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 18 at defaults).
- Pulses: rise_pulse/fall_pulse are registered and coincide with the first cycle of the new clean level. Each is high for exactly one cycle and never both at once on a channel.
- cnt: width $clog2(DEBOUNCE_CYCLES); it never wraps because the terminal compare precedes the increment.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses, with no arbitration.
- Input held constant: no output activity.
- Input toggling faster than DEBOUNCE_CYCLES: clean_out never changes.
- Power-up with a pin already high: the channel qualifies from ST_LO normally and emits one rise_pulse at edge SYNC_STAGES+DEBOUNCE_CYCLES after reset release.

Optional Feature:
- Macro QUAD_INPUT_GLITCH_CNT_EN.
- Defined:
  - The glitch_cnt port exists.
  - Each channel has an 8-bit counter that increments on every ST_WAIT_HI->ST_LO or ST_WAIT_LO->ST_HI abort.
  - The counter saturates at 255 and is cleared only by rst. Channel i occupies bits [8*i+7:8*i].
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package quad_input_pkg holds:
  - the 2-bit state typedef: ST_LO=2'b00, ST_WAIT_HI=2'b01, ST_HI=2'b11, ST_WAIT_LO=2'b10;
  - GLITCH_CNT_W=8;
  - default SYNC_STAGES and DEBOUNCE_CYCLES constants.
- One sub-module, debounce_channel, holds the single-channel synchronizer, FSM, counter and optional glitch counter. The top instantiates NUM_CH copies in a generate loop.

Test Plan:
- Reset behaviour: assert rst for 3 cycles with raw_in=3'b111, then release -> all outputs 0 during reset. clean_out=3'b111 and rise_pulse=3'b111 for one cycle appear at edge 18 after release, with no pulse earlier.
- Clean edge: raw_in[1] goes 0->1 and is held -> clean_out[1] rises exactly 18 edges after capture, with a single rise_pulse[1]. Drop it back -> fall_pulse[1] one cycle, clean_out[1]=0 after 18 edges.
- Glitch rejection: raw_in[2] high for 10 cycles, then low -> clean_out[2] stays 0, no pulses. With QUAD_INPUT_GLITCH_CNT_EN, glitch_cnt[23:16]=1.
- Boundary: raw_in[0] high for exactly 15 synchronized cycles -> rejected. High for 16 -> accepted. Use DEBOUNCE_CYCLES=16.
- Mid-operation reset: assert rst at cnt=12 in ST_WAIT_HI -> next cycle cnt=0, state ST_LO, no rise_pulse. Re-qualification requires a full 16 samples.
- Saturation: apply 300 glitches on channel 0 with the macro defined -> glitch_cnt[7:0]=255 and holds.
